// File: rtl/core_pkg.sv
// Shared RV32I front-end definitions: PC redirect command encodings and fetch sequencer states.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_RSVD   = 2'd3
  } pc_c_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational redirect target: absolute jump or PC-relative branch, word-aligned, with misalign flag.
module pc_target_gen
  import core_pkg::*;
(
  input  logic [1:0]      ju_pc_c_i,
  input  logic [XLEN-1:0] ju_target_i,
  input  logic [12:0]     ju_imm_i,
  input  logic [XLEN-1:0] ju_pc_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw        = '0;
    redirect_o = 1'b0;
    case (ju_pc_c_i)
      PC_JUMP: begin
        raw        = {ju_target_i[XLEN-1:1], 1'b0};
        redirect_o = 1'b1;
      end
      PC_BRANCH: begin
        raw        = ju_pc_i + {{19{ju_imm_i[12]}}, ju_imm_i};
        raw[0]     = 1'b0;
        redirect_o = 1'b1;
      end
      default: begin
        raw        = '0;
        redirect_o = 1'b0;
      end
    endcase
    // Misaligned targets are still taken, just forced onto a word boundary.
    misalign_o = redirect_o & raw[1];
    target_o   = {raw[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer and instruction fetch controller: req/ack fetch, decode hand-off, redirect flush.
module pc_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ju_pc_c,
  input  logic [31:0] ju_target,
  input  logic [12:0] ju_imm,
  input  logic [31:0] ju_pc,
  input  logic        stall_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        flush_out,
  output logic        misalign
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         flush_q, flush_d;
  logic         mis_q, mis_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         drop_q, drop_d;

  logic         redirect;
  logic [31:0]  target;
  logic         target_mis;
  logic         ack_seen;

  pc_target_gen u_target (
    .ju_pc_c_i   (ju_pc_c),
    .ju_target_i (ju_target),
    .ju_imm_i    (ju_imm),
    .ju_pc_i     (ju_pc),
    .redirect_o  (redirect),
    .target_o    (target),
    .misalign_o  (target_mis)
  );

  assign ack_seen = req_q & imem_ack;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    flush_d  = flush_q;
    mis_d    = 1'b0;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    if (redirect) begin
      pc_d    = target;
      cnt_d   = FLUSH_LOAD;
      state_d = FLUSH;
      valid_d = 1'b0;
      flush_d = 1'b1;
      mis_d   = target_mis;
      // An in-flight fetch must still complete on the bus; remember to discard it.
      if (ack_seen) begin
        req_d  = 1'b0;
        drop_d = 1'b0;
      end else if (req_q) begin
        drop_d = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          state_d = WAIT;
          // A stale request still pending keeps the bus; WAIT re-issues once it is acked.
          if (!req_q || imem_ack) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            drop_d = 1'b0;
          end
        end
        WAIT: begin
          if (ack_seen) begin
            if (drop_q) begin
              drop_d = 1'b0;
              addr_d = pc_q;
            end else begin
              pc_out_d = pc_q;
              instr_d  = imem_rdata;
              valid_d  = 1'b1;
              pc_d     = pc_q + 32'd4;
              req_d    = 1'b0;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        FLUSH: begin
          if (ack_seen) begin
            req_d  = 1'b0;
            drop_d = 1'b0;
          end
          if (cnt_q <= 3'd1) begin
            cnt_d   = '0;
            flush_d = 1'b0;
            state_d = FETCH;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc_out      = pc_out_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign flush_out   = flush_q;
  assign misalign    = mis_q;

endmodule
